kuart_rx_deserializer: RTL

- Simulation-support receiver that turns the SoC's kernel UART TX pin (8N1, LSB first) into a byte stream.
- Drives the finisher's byte/valid inputs (kuart_from_cpu, kuart_from_cpu_valid), replacing the behavioural tap on the internal UART FIFO.
- Gives the end-of-simulation detector pin-level visibility, identical on FPGA and ASIC netlists.
- Mid-bit sampling against a fixed clocks-per-bit divisor; framing errors are flagged, never forwarded.

---
 rtl/sim_uart_pkg.sv | 16 +
 rtl/sim_sync_ff.sv | 24 ++
 rtl/kuart_rx_deserializer.sv | 111 +++++++++++
 3 files changed

// File: rtl/sim_uart_pkg.sv
// Shared definitions for the simulation-side UART helpers (receive FSM states,
// frame geometry and line idle level).
package sim_uart_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_e;

endpackage

// File: rtl/sim_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; the reset value
// lets the serial line come out of reset at its idle level.
module sim_sync_ff
   import sim_uart_pkg::*;
#(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = IDLE_LEVEL
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync;

   always_ff @(posedge clk) begin
      if (reset) sync <= {STAGES{RESET_VAL}};
      else       sync <= {sync[STAGES-2:0], d};
   end

   assign q = sync[STAGES-1];

endmodule

// File: rtl/kuart_rx_deserializer.sv
// 8N1 UART receiver for the kernel UART TX pin: mid-bit sampling with a fixed
// divisor, forwards correctly framed bytes and flags bad stop bits.
module kuart_rx_deserializer
   import sim_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        LAST_IDX = 3'(DATA_BITS - 1);

   rx_state_e            state, state_next;
   logic                 rs, rs_prev;
   logic [CNT_W-1:0]     cnt;
   logic [2:0]           idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 start_det, tick, shift_en, valid_set, err_set, busy_next;

   sim_sync_ff #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (IDLE_LEVEL)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rs)
   );

   assign start_det = (rs == ~IDLE_LEVEL) && (rs_prev == IDLE_LEVEL);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rs_prev <= IDLE_LEVEL;
      end else begin
         state   <= state_next;
         rs_prev <= rs;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_det) state_next = START;
         START:   if (tick) state_next = (rs == IDLE_LEVEL) ? IDLE : DATA;
         DATA:    if (tick && idx == LAST_IDX) state_next = STOP;
         STOP:    if (tick) state_next = (rs == IDLE_LEVEL) ? IDLE : BREAK;
         BREAK:   if (rs == IDLE_LEVEL) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // START waits half a bit to land mid-bit; later states wait a full bit.
   always_comb begin
      tick      = 1'b0;
      shift_en  = 1'b0;
      valid_set = 1'b0;
      err_set   = 1'b0;
      case (state)
         START:      tick = (cnt == HALF_M1);
         DATA, STOP: tick = (cnt == FULL_M1);
         default:    tick = 1'b0;
      endcase
      shift_en  = (state == DATA) && tick;
      valid_set = (state == STOP) && tick && (rs == IDLE_LEVEL);
      err_set   = (state == STOP) && tick && (rs != IDLE_LEVEL);
      busy_next = (state != IDLE) || (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         if (state == IDLE || state == BREAK || tick) cnt <= '0;
         else                                         cnt <= cnt + 1'b1;
         if (state == START)  idx <= '0;
         else if (shift_en)   idx <= idx + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (shift_en) shreg <= {rs, shreg[DATA_BITS-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (valid_set) rx_data <= shreg;
         rx_valid  <= valid_set;
         frame_err <= err_set;
         busy      <= busy_next;
      end
   end

endmodule
